// File: rtl/vector_checker_pkg.sv
// Shared definitions for the vector checker: FSM state encodings.
package vector_checker_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/vector_mem.sv
// Expected-vector table: DEPTH entries of {mask,data}, synchronous write, asynchronous read.
module vector_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] rmask
);

  // Contents deliberately survive reset so a table can be reused across runs.
  logic [2*DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= {wmask, wdata};
  end

  assign rdata = mem[raddr][DATA_W-1:0];
  assign rmask = mem[raddr][2*DATA_W-1:DATA_W];

endmodule

// File: rtl/vector_checker.sv
// Compares DUT samples against a preloaded masked table; counts mismatches, captures the first one.
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_wdata,
  input  logic [DATA_W-1:0] exp_wmask,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_seen,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] exp_mask;
  logic              accept;
  logic              mis;
  logic [ERR_W-1:0]  err_inc;
  logic [ERR_W-1:0]  err_next;

  // Table is frozen while a run is in progress.
  vector_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clock (clock),
    .we    (exp_we && (state != ST_RUN)),
    .waddr (exp_addr),
    .wdata (exp_wdata),
    .wmask (exp_wmask),
    .raddr (idx),
    .rdata (exp_data),
    .rmask (exp_mask)
  );

  assign sample_ready = (state == ST_RUN);
  assign busy         = (state == ST_RUN);
  assign done         = (state == ST_DONE);
  assign accept       = sample_valid && sample_ready;
  assign mis          = |((sample_data ^ exp_data) & exp_mask);
  assign err_inc      = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
  assign err_next     = mis ? err_inc : err_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      err_count      <= '0;
      first_err_seen <= 1'b0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_RUN;
            idx            <= '0;
            err_count      <= '0;
            first_err_seen <= 1'b0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            pass           <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            err_count <= err_next;
            if (mis && !first_err_seen) begin
              first_err_seen <= 1'b1;
              first_err_idx  <= idx;
              first_err_data <= sample_data;
            end
            if (idx == LAST_IDX) begin
              // Final compare folds into pass on the same edge that ends the run.
              state <= ST_DONE;
              idx   <= '0;
              pass  <= (err_next == '0);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// Randomized self-checking bench for vector_checker; a wide (ERR_W=8) and a narrow (ERR_W=2) instance share stimulus.
module tb_vector_checker;

  logic       clock = 1'b0;
  logic       reset_n, exp_we, start, sample_valid;
  logic [3:0] exp_addr;
  logic [7:0] exp_wdata, exp_wmask, sample_data;

  logic       a_ready, a_busy, a_done, a_pass, a_seen;
  logic [7:0] a_err;
  logic [3:0] a_fidx;
  logic [7:0] a_fdata;
  logic       b_ready, b_busy, b_done, b_pass, b_seen;
  logic [1:0] b_err;
  logic [3:0] b_fidx;
  logic [7:0] b_fdata;

  always #5 clock = ~clock;

  vector_checker #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .ERR_W(8)) u_dut (
    .clock(clock), .reset_n(reset_n), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_wdata(exp_wdata), .exp_wmask(exp_wmask), .start(start),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(a_ready),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_err_seen(a_seen), .first_err_idx(a_fidx), .first_err_data(a_fdata)
  );

  vector_checker #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .ERR_W(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_wdata(exp_wdata), .exp_wmask(exp_wmask), .start(start),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(b_ready),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_err_seen(b_seen), .first_err_idx(b_fidx), .first_err_data(b_fdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the table as the bench believes it is, plus per-run results.
  logic [7:0] m_exp [16];
  logic [7:0] m_mask[16];
  logic [7:0] smp   [16];
  int         m_cnt;
  bit         m_seen;
  int         m_fidx;
  logic [7:0] m_fdata;

  // Optional side actions inside a run.
  int         run_we_at;
  bit         start_we;
  logic [3:0] sw_addr;
  logic [7:0] sw_data, sw_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_accept(input int i, input logic [7:0] d);
    if (((d ^ m_exp[i]) & m_mask[i]) != 8'h00) begin
      m_cnt++;
      if (!m_seen) begin
        m_seen  = 1'b1;
        m_fidx  = i;
        m_fdata = d;
      end
    end
  endtask

  task automatic write_entry(input int a, input logic [7:0] d, input logic [7:0] m);
    exp_we = 1'b1; exp_addr = 4'(a); exp_wdata = d; exp_wmask = m;
    tick();
    exp_we = 1'b0;
    m_exp[a] = d; m_mask[a] = m;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".ready"}, 32'(a_ready), 0);
    check({tag, ".busy"},  32'(a_busy),  0);
    check({tag, ".done"},  32'(a_done),  0);
    check({tag, ".pass"},  32'(a_pass),  0);
    check({tag, ".err"},   32'(a_err),   0);
    check({tag, ".seen"},  32'(a_seen),  0);
    check({tag, ".fidx"},  32'(a_fidx),  0);
    check({tag, ".fdata"}, 32'(a_fdata), 0);
    check({tag, ".b_err"}, 32'(b_err),   0);
    check({tag, ".b_done"}, 32'(b_done), 0);
  endtask

  task automatic check_final(input string tag);
    check({tag, ".done"},   32'(a_done),  1);
    check({tag, ".busy"},   32'(a_busy),  0);
    check({tag, ".pass"},   32'(a_pass),  32'(m_cnt == 0));
    check({tag, ".err"},    32'(a_err),   32'(sat(m_cnt, 8)));
    check({tag, ".seen"},   32'(a_seen),  32'(m_seen));
    check({tag, ".fidx"},   32'(a_fidx),  32'(m_fidx));
    check({tag, ".fdata"},  32'(a_fdata), 32'(m_fdata));
    check({tag, ".b_err"},  32'(b_err),   32'(sat(m_cnt, 2)));
    check({tag, ".b_pass"}, 32'(b_pass),  32'(m_cnt == 0));
    check({tag, ".b_fidx"}, 32'(b_fidx),  32'(m_fidx));
  endtask

  task automatic run(input bit gaps, input string tag);
    int i, cyc;
    start = 1'b1;
    if (start_we) begin
      exp_we = 1'b1; exp_addr = sw_addr; exp_wdata = sw_data; exp_wmask = sw_mask;
      m_exp[sw_addr] = sw_data; m_mask[sw_addr] = sw_mask;
    end
    tick();
    start = 1'b0; exp_we = 1'b0; start_we = 1'b0;
    m_cnt = 0; m_seen = 1'b0; m_fidx = 0; m_fdata = 8'h00;
    check({tag, ".busy0"},  32'(a_busy),  1);
    check({tag, ".ready0"}, 32'(a_ready), 1);
    check({tag, ".err0"},   32'(a_err),   0);
    i = 0; cyc = 0;
    while (i < 16 && cyc < 400) begin
      sample_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      sample_data  = smp[i];
      if (i == run_we_at) begin
        exp_we = 1'b1; exp_addr = 4'd2; exp_wdata = 8'h77; exp_wmask = 8'hFF;
      end
      tick();
      exp_we = 1'b0; cyc++;
      if (sample_valid) begin
        model_accept(i, smp[i]);
        i++;
        if (i < 16) check({tag, ".err_run"}, 32'(a_err), 32'(sat(m_cnt, 8)));
      end
    end
    sample_valid = 1'b0;
    run_we_at = -1;
    check_final(tag);
  endtask

  initial begin
    reset_n = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wmask = '0;
    start = 1'b0; sample_valid = 1'b0; sample_data = '0;
    run_we_at = -1; start_we = 1'b0;
    sw_addr = '0; sw_data = '0; sw_mask = '0;
    tick(); tick();
    check_idle_zero("reset");
    reset_n = 1'b1;
    tick();
    check_idle_zero("post_reset");

    for (int i = 0; i < 16; i++) write_entry(i, 8'(i), 8'hFF);

    // Samples offered while idle must be dropped.
    sample_valid = 1'b1; sample_data = 8'hEE;
    repeat (3) tick();
    sample_valid = 1'b0;
    check_idle_zero("idle_drop");

    for (int i = 0; i < 16; i++) smp[i] = 8'(i);
    run(1'b0, "t1_clean");

    // Samples offered in DONE are dropped too.
    sample_valid = 1'b1; sample_data = 8'h00;
    repeat (3) tick();
    sample_valid = 1'b0;
    check_final("done_drop");

    smp[5] = 8'hA5;
    run(1'b0, "t2_one_err");
    smp[5] = 8'h05;

    write_entry(3, 8'h0F, 8'h0F);
    smp[3] = 8'hFF;
    run(1'b1, "t3_masked");
    write_entry(3, 8'h0F, 8'hFF);
    run(1'b1, "t3_unmasked");
    write_entry(3, 8'h03, 8'hFF);

    for (int i = 0; i < 16; i++) smp[i] = ~8'(i);
    run(1'b0, "t4_saturate");

    // A write issued mid-run must not land; next run sees the original entry.
    for (int i = 0; i < 16; i++) smp[i] = 8'(i);
    run_we_at = 4;
    run(1'b1, "t5_we_in_run");
    run(1'b0, "t5_table_intact");

    // Write coinciding with start lands and is used by that run.
    start_we = 1'b1; sw_addr = 4'd0; sw_data = 8'h55; sw_mask = 8'hFF;
    smp[0] = 8'h55;
    run(1'b0, "t5_write_start");

    // Reset in the middle of a run.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample_valid = 1'b1; sample_data = 8'hC3;
      tick();
    end
    check("mid.err_before_reset", 32'(a_err), 7);
    reset_n = 1'b0; sample_valid = 1'b1;
    tick();
    reset_n = 1'b1; sample_valid = 1'b0;
    check_idle_zero("mid_reset");
    tick();
    check_idle_zero("mid_reset_hold");
    run(1'b1, "t5_restart");

    // Random tables, masks (including don't-care slots) and samples.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] m;
        m = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        write_entry(i, 8'($urandom), m);
        smp[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_exp[i];
      end
      run(1'(r % 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
